// File: rtl/mem_ctrl_if.sv
// Request/response and memory-bus signals of mem_ctrl.
// slave = the controller, master = the CPU/memory environment driving it.
interface mem_ctrl_if;
  logic        rdy_in;
  logic        clear_in;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_valid;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  modport slave (
    input  rdy_in, clear_in, mem_din, io_buffer_full,
           if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr, if_done, if_data, ls_done, ls_rdata
  );
  modport master (
    output rdy_in, clear_in, mem_din, io_buffer_full,
           if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, ls_done, ls_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch vs load/store and serialises each request
// into byte-wide bus cycles; little-endian assembly, I/O write throttling.
module mem_ctrl (
  input  logic      clk_in,
  input  logic      rst_in,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_is_if;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;
  logic        r_if_done;
  logic        r_ls_done;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;

  logic        w_io;
  logic        w_req_io;
  logic [2:0]  w_ls_n;
  logic [1:0]  w_idx;
  logic [31:0] w_cap;
  logic [7:0]  w_wbyte;
  logic [31:0] w_next_a;

  assign w_io     = (r_base[17:16] == 2'b11);
  assign w_req_io = (bus.ls_addr[17:16] == 2'b11);

  // Illegal size 2'b11 is handled as a word.
  always_comb begin
    case (bus.ls_size)
      2'b00:   w_ls_n = 3'd1;
      2'b01:   w_ls_n = 3'd2;
      default: w_ls_n = 3'd4;
    endcase
  end

  // In READ, r_cnt counts addresses issued; mem_din carries byte r_cnt-2.
  assign w_idx = r_cnt[1:0] - 2'd2;

  always_comb begin
    w_cap = r_buf;
    w_cap[{w_idx, 3'b000} +: 8] = bus.mem_din;
  end

  assign w_wbyte  = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
  assign w_next_a = r_base + {29'd0, r_cnt};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_is_if    <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= '0;
      r_ls_rdata <= '0;
    end else if (bus.rdy_in) begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mem_a  <= '0;
          r_mem_wr <= 1'b0;
          r_cnt    <= '0;
          r_buf    <= '0;
          if (bus.ls_valid) begin
            r_base  <= bus.ls_addr;
            r_wdata <= bus.ls_wdata;
            r_n     <= w_ls_n;
            r_is_if <= 1'b0;
            if (bus.ls_wr) begin
              r_state <= WRITE;
              if (!(w_req_io && bus.io_buffer_full)) begin
                r_mem_a    <= bus.ls_addr;
                r_mem_wr   <= 1'b1;
                r_mem_dout <= bus.ls_wdata[7:0];
                r_cnt      <= 3'd1;
              end
            end else begin
              r_state <= READ;
              r_mem_a <= bus.ls_addr;
              r_cnt   <= 3'd1;
            end
          end else if (bus.if_valid && !bus.clear_in) begin
            r_base  <= bus.if_addr;
            r_n     <= 3'd4;
            r_is_if <= 1'b1;
            r_state <= READ;
            r_mem_a <= bus.if_addr;
            r_cnt   <= 3'd1;
          end
        end
        READ: begin
          if (r_is_if && bus.clear_in) begin
            r_state <= IDLE;
            r_mem_a <= '0;
            r_cnt   <= '0;
          end else begin
            if (r_cnt >= 3'd2) r_buf <= w_cap;
            if (r_cnt < r_n) begin
              r_mem_a <= w_next_a;
              r_cnt   <= r_cnt + 3'd1;
            end else if (r_cnt == r_n) begin
              // last byte still in flight: bus idles for the capture cycle
              r_mem_a <= '0;
              r_cnt   <= r_cnt + 3'd1;
            end else begin
              r_state <= DONE;
              if (r_is_if) begin
                r_if_data <= w_cap;
                r_if_done <= 1'b1;
              end else begin
                r_ls_rdata <= w_cap;
                r_ls_done  <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          if ((w_io && r_mem_wr) || (r_cnt != r_n && w_io && bus.io_buffer_full)) begin
            // idle after each I/O byte so the full flag's lag is covered
            r_mem_wr <= 1'b0;
            r_mem_a  <= '0;
          end else if (r_cnt == r_n) begin
            r_state   <= DONE;
            r_mem_wr  <= 1'b0;
            r_mem_a   <= '0;
            r_ls_done <= 1'b1;
          end else begin
            r_mem_a    <= w_next_a;
            r_mem_wr   <= 1'b1;
            r_mem_dout <= w_wbyte;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_mem_a  <= '0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_a    = r_mem_a;
  assign bus.mem_wr   = r_mem_wr;
  assign bus.mem_dout = r_mem_dout;
  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model on the bus, hand sequences for
// multi-cycle corners, then a table of load/store vectors.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic init_mem;
  int   total = 0;
  int   bad   = 0;

  mem_ctrl_if bus();
  mem_ctrl dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  logic [7:0] eb [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  // RAM: synchronous read, paused together with the controller; I/O writes are not stored.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      ram[16'h1004] <= 8'h13; ram[16'h1005] <= 8'h05;
      ram[16'h1006] <= 8'h10; ram[16'h1007] <= 8'h00;
      ram[16'h2000] <= 8'h11; ram[16'h2001] <= 8'hAB;
      ram[16'h2002] <= 8'hCD; ram[16'h2003] <= 8'h22;
      ram[16'h0104] <= 8'h5A;
      ram[16'hFFFE] <= 8'h01; ram[16'hFFFF] <= 8'h02;
      ram[16'h0000] <= 8'h03; ram[16'h0001] <= 8'h04;
    end else if (bus.rdy_in) begin
      if (bus.mem_wr && bus.mem_a[17:16] != 2'b11) ram[bus.mem_a[15:0]] <= bus.mem_dout;
      bus.mem_din <= ram[bus.mem_a[15:0]];
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_ls(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] data);
    bus.ls_valid = 1'b1; bus.ls_wr = wr; bus.ls_size = sz;
    bus.ls_addr = addr; bus.ls_wdata = wd;
    lat = -1; data = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) bus.ls_valid = 1'b0;
      if (bus.ls_done) begin
        lat = c; data = bus.ls_rdata;
        break;
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] data;
    rst = 1'b1; init_mem = 1'b1;
    bus.rdy_in = 1'b1; bus.clear_in = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_valid = 1'b0; bus.if_addr = '0;
    bus.ls_valid = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = '0;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    tick(); tick();
    init_mem = 1'b0;
    tick();
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("rst_if_done", {31'd0, bus.if_done}, 32'h0);
    chk("rst_ls_done", {31'd0, bus.ls_done}, 32'h0);
    chk("rst_if_data", bus.if_data, 32'h0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // word fetch: addresses in cycles 1..4, done in cycle 6
    bus.if_valid = 1'b1; bus.if_addr = 32'h0000_1004;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) bus.if_valid = 1'b0;
      if (c <= 4) chk("fetch_mem_a", bus.mem_a, 32'(32'h1003 + c));
      chk("fetch_done", {31'd0, bus.if_done}, {31'd0, c == 6});
    end
    chk("fetch_data", bus.if_data, 32'h0010_0513);
    tick();

    // store beats a simultaneous fetch; fetch served afterwards
    bus.ls_valid = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h0000_0FFE; bus.ls_wdata = 32'hDEAD_BEEF;
    bus.if_valid = 1'b1; bus.if_addr = 32'h0000_1004;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) bus.ls_valid = 1'b0;
      if (c == 7) bus.if_valid = 1'b0;
      if (c <= 4) begin
        chk("arb_mem_wr", {31'd0, bus.mem_wr}, 32'h1);
        chk("arb_mem_a", bus.mem_a, 32'(32'hFFD + c));
        chk("arb_mem_dout", {24'd0, bus.mem_dout}, {24'd0, eb[c-1]});
      end
      if (c <= 5) chk("arb_ls_done", {31'd0, bus.ls_done}, {31'd0, c == 5});
      chk("arb_if_done", {31'd0, bus.if_done}, {31'd0, c == 12});
    end
    chk("arb_if_data", bus.if_data, 32'h0010_0513);
    chk("arb_ram", {ram[16'h1001], ram[16'h1000], ram[16'h0FFF], ram[16'h0FFE]}, 32'hDEAD_BEEF);
    tick();

    // I/O byte store; flag seen high at the first three sampling edges
    bus.io_buffer_full = 1'b1;
    bus.ls_valid = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b00;
    bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h0000_0041;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) bus.ls_valid = 1'b0;
      if (c == 3) bus.io_buffer_full = 1'b0;
      chk("io_mem_wr", {31'd0, bus.mem_wr}, {31'd0, c == 4});
      if (c == 4) begin
        chk("io_mem_a", bus.mem_a, 32'h0003_0000);
        chk("io_mem_dout", {24'd0, bus.mem_dout}, 32'h41);
      end
      if (c == 5) chk("io_gap_a", bus.mem_a, 32'h0);
      chk("io_ls_done", {31'd0, bus.ls_done}, {31'd0, c == 6});
    end
    tick();

    // clear aborts a fetch; the queued half load then runs
    bus.if_valid = 1'b1; bus.if_addr = 32'h0000_1004;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) bus.if_valid = 1'b0;
      if (c == 3) begin
        bus.clear_in = 1'b1;
        bus.ls_valid = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b01;
        bus.ls_addr = 32'h0000_2001;
      end
      if (c == 4) begin
        bus.clear_in = 1'b0;
        chk("clr_mem_a", bus.mem_a, 32'h0);
      end
      if (c == 5) bus.ls_valid = 1'b0;
      chk("clr_if_done", {31'd0, bus.if_done}, 32'h0);
      chk("clr_ls_done", {31'd0, bus.ls_done}, {31'd0, c == 8});
    end
    chk("clr_ls_rdata", bus.ls_rdata, 32'h0000_CDAB);
    tick();

    // pause for three cycles in the middle of a word load
    bus.ls_valid = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h0000_2000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) bus.ls_valid = 1'b0;
      if (c == 2) bus.rdy_in = 1'b0;
      if (c >= 2 && c <= 5) chk("rdy_mem_a", bus.mem_a, 32'h0000_2001);
      if (c == 5) bus.rdy_in = 1'b1;
      chk("rdy_ls_done", {31'd0, bus.ls_done}, {31'd0, c == 9});
    end
    chk("rdy_ls_rdata", bus.ls_rdata, 32'h22CD_AB11);
    tick();

    // reset in the middle of a word store
    bus.ls_valid = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h0000_3000; bus.ls_wdata = 32'h1234_5678;
    tick();
    bus.ls_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_mem_a", bus.mem_a, 32'h0);
    chk("mrst_mem_wr", {31'd0, bus.mem_wr}, 32'h0);
    chk("mrst_mem_dout", {24'd0, bus.mem_dout}, 32'h0);
    chk("mrst_ls_rdata", bus.ls_rdata, 32'h0);
    chk("mrst_if_data", bus.if_data, 32'h0);
    chk("mrst_ram", {8'h00, ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'h0000_5678);
    rst = 1'b0;
    tick();

    // table: latency = cycles from request to done
    vecs[0] = '{1'b1, 2'b10, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         5};
    vecs[1] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 6};
    vecs[2] = '{1'b1, 2'b01, 32'h0000_0101, 32'h1234_BEEF, 32'h0,         3};
    vecs[3] = '{1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hCABE_EF0D, 6};
    vecs[4] = '{1'b0, 2'b00, 32'h0000_0103, 32'h0,         32'h0000_00CA, 3};
    vecs[5] = '{1'b0, 2'b01, 32'h0000_0102, 32'h0,         32'h0000_CABE, 4};
    vecs[6] = '{1'b0, 2'b10, 32'h0000_0103, 32'h0,         32'h0000_5ACA, 6};
    vecs[7] = '{1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'h0403_0201, 6};
    vecs[8] = '{1'b1, 2'b00, 32'h0000_0200, 32'hAAAA_AA77, 32'h0,         2};
    vecs[9] = '{1'b0, 2'b01, 32'h0000_01FF, 32'h0,         32'h0000_7700, 4};
    for (int i = 0; i < 10; i++) begin
      run_ls(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, lat, data);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      if (!vecs[i].wr) chk($sformatf("vec%0d_data", i), data, vecs[i].exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
